// File: rtl/single_pulser.sv
// single_pulser: turns each synchronized, debounced press level into one
// pulse of PULSE_LEN cycles per press. A new pulse needs a release and
// another press. WIDTH channels run independently on one clock and one reset.
//
// Optional build macro: SINGLE_PULSER_CNT_EN adds an 8-bit press counter per
// channel on press_cnt_o. The counter wraps 255 -> 0.
//
// Per-channel FSM
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for a press, SP_o = 0
//   PULSE   | pulse in progress, SP_o = 1, timer counts down to 0
//   HOLD    | pulse finished but press still held, SP_o = 0
//   (2'b11) | unused code, recovers to IDLE

module single_pulser #(
  parameter int WIDTH     = 1,
  parameter int PULSE_LEN = 1    // legal range 1..255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   syncpress_i,
  output logic [WIDTH-1:0]   SP_o
`ifdef SINGLE_PULSER_CNT_EN
  ,
  output logic [8*WIDTH-1:0] press_cnt_o
`endif
);

  // The timer is loaded with PULSE_LEN-1 and PULSE exits on the terminal
  // count of 0, so the pulse lasts PULSE_LEN cycles.
  localparam logic [7:0] TMR_LOAD = 8'(PULSE_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PULSE = 2'b01,
    S_HOLD  = 2'b10
  } state_e;

  state_e           state_q [WIDTH];
  state_e           state_d [WIDTH];
  logic [7:0]       tmr_q   [WIDTH];
  logic [7:0]       tmr_d   [WIDTH];
  logic [WIDTH-1:0] sp_q;
  logic [WIDTH-1:0] sp_d;

  // Next-state, timer and registered-output decode for every channel.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      tmr_d[i]   = tmr_q[i];
      case (state_q[i])
        S_IDLE: begin
          if (syncpress_i[i]) begin
            state_d[i] = S_PULSE;
            tmr_d[i]   = TMR_LOAD;
          end
        end
        S_PULSE: begin
          // The input is ignored until the timer expires. After that the
          // level decides whether the press is still being held.
          if (tmr_q[i] != 8'd0) begin
            tmr_d[i] = tmr_q[i] - 8'd1;
          end else if (syncpress_i[i]) begin
            state_d[i] = S_HOLD;
          end else begin
            state_d[i] = S_IDLE;
          end
        end
        S_HOLD: begin
          if (!syncpress_i[i]) begin
            state_d[i] = S_IDLE;
          end
        end
        default: begin
          state_d[i] = S_IDLE;
        end
      endcase
      // SP_o comes from a flop that mirrors the next state, so the output
      // has no combinational path from syncpress_i.
      sp_d[i] = (state_d[i] == S_PULSE);
    end
  end

  // State, timer and pulse registers. Reset wins over any input value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= S_IDLE;
        tmr_q[i]   <= 8'd0;
      end
      sp_q <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      sp_q    <= sp_d;
    end
  end

  assign SP_o = sp_q;

`ifdef SINGLE_PULSER_CNT_EN
  logic [7:0] pcnt_q [WIDTH];
  logic [7:0] pcnt_d [WIDTH];

  // Count IDLE->PULSE transitions. The count updates on the same edge that
  // SP_o rises, and wraps naturally at 8 bits.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      pcnt_d[i] = pcnt_q[i];
      if (state_q[i] == S_IDLE && state_d[i] == S_PULSE) begin
        pcnt_d[i] = pcnt_q[i] + 8'd1;
      end
    end
  end

  // Press counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        pcnt_q[i] <= 8'd0;
      end
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

  // Pack the per-channel counts onto the flat output bus.
  always_comb begin
    press_cnt_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      press_cnt_o[8*i +: 8] = pcnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_single_pulser.sv
// Testbench for single_pulser. Two instances are driven from the same stimulus:
//   dut_a: WIDTH=2, PULSE_LEN=3
//   dut_b: WIDTH=1, PULSE_LEN=1, fed from press bit 0
// Expected outputs are queued by the driver and checked by a separate monitor.

module tb_single_pulser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  press = 2'bxx;
  logic [1:0]  sp_a;
  logic [0:0]  sp_b;
`ifdef SINGLE_PULSER_CNT_EN
  logic [15:0] cnt_a;
  logic [7:0]  cnt_b;
`endif

  always #5 clk = ~clk;

  single_pulser #(.WIDTH(2), .PULSE_LEN(3)) dut_a (
    .clk         (clk),
    .rst         (rst),
    .syncpress_i (press),
    .SP_o        (sp_a)
`ifdef SINGLE_PULSER_CNT_EN
    ,
    .press_cnt_o (cnt_a)
`endif
  );

  single_pulser #(.WIDTH(1), .PULSE_LEN(1)) dut_b (
    .clk         (clk),
    .rst         (rst),
    .syncpress_i (press[0:0]),
    .SP_o        (sp_b)
`ifdef SINGLE_PULSER_CNT_EN
    ,
    .press_cnt_o (cnt_b)
`endif
  );

  typedef struct packed {
    logic [1:0]  sp_a;
    logic        sp_b;
    logic [15:0] cnt_a;
    logic [7:0]  cnt_b;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model. Channels 0 and 1 model dut_a; channel 2 models dut_b.
  // Each channel tracks:
  //   busy  - remaining pulse cycles
  //   armed - a release has been seen since the last pulse
  //   pc    - number of pulses started
  int         busy  [3];
  bit         armed [3];
  logic [7:0] pc    [3];
  int         plen  [3] = '{3, 3, 1};

  function automatic void model_edge(input logic r, input logic [1:0] p);
    logic pin;
    for (int c = 0; c < 3; c++) begin
      pin = (c == 2) ? p[0] : p[c];
      if (r) begin
        busy[c]  = 0;
        armed[c] = 1'b1;
        pc[c]    = 8'd0;
      end else if (busy[c] > 0) begin
        busy[c] = busy[c] - 1;
        if (busy[c] == 0) armed[c] = !pin;
      end else if (pin) begin
        if (armed[c]) begin
          busy[c]  = plen[c];
          armed[c] = 1'b0;
          pc[c]    = pc[c] + 8'd1;
        end
      end else begin
        armed[c] = 1'b1;
      end
    end
  endfunction

  function automatic void chk(input string n, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
    end
  endfunction

  // Drive one edge's worth of stimulus and queue what must appear after it.
  task automatic step(input logic r, input logic [1:0] p);
    exp_t e;
    @(negedge clk);
    rst   = r;
    press = p;
    model_edge(r, p);
    e.sp_a  = {busy[1] > 0, busy[0] > 0};
    e.sp_b  = busy[2] > 0;
    e.cnt_a = {pc[1], pc[0]};
    e.cnt_b = pc[2];
    exp_q.push_back(e);
  endtask

  task automatic rep(input logic r, input logic [1:0] p, input int n);
    for (int k = 0; k < n; k++) step(r, p);
  endtask

  // Monitor: compare the DUT outputs just after each active edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sp_a", 32'(sp_a), 32'(e.sp_a));
      chk("sp_b", 32'(sp_b), 32'(e.sp_b));
`ifdef SINGLE_PULSER_CNT_EN
      chk("cnt_a", 32'(cnt_a), 32'(e.cnt_a));
      chk("cnt_b", 32'(cnt_b), 32'(e.cnt_b));
`endif
    end
  end

  initial begin
    logic       r;
    logic [1:0] p;

    // Reset with an unknown input.
    rep(1'b1, 2'bxx, 2);

    // Held press followed by a re-press.
    rep(1'b0, 2'b00, 1);
    rep(1'b0, 2'b01, 3);
    rep(1'b0, 2'b00, 1);
    rep(1'b0, 2'b01, 4);
    rep(1'b0, 2'b00, 4);

    // Short press stretched to a full pulse; a press during the pulse is ignored.
    rep(1'b0, 2'b01, 1);
    rep(1'b0, 2'b00, 1);
    rep(1'b0, 2'b01, 1);
    rep(1'b0, 2'b00, 5);

    // Reset in the middle of a pulse, with the press held through reset release.
    rep(1'b0, 2'b11, 1);
    rep(1'b0, 2'b00, 1);
    rep(1'b1, 2'b11, 1);
    rep(1'b0, 2'b11, 5);
    rep(1'b0, 2'b00, 2);

    // Independent channels.
    rep(1'b0, 2'b00, 4);
    rep(1'b0, 2'b01, 2);
    rep(1'b0, 2'b11, 3);
    rep(1'b0, 2'b00, 4);

    // Random stimulus: inputs toggle occasionally and reset is asserted rarely.
    p = 2'b00;
    for (int k = 0; k < 3000; k++) begin
      for (int b = 0; b < 2; b++)
        if ($urandom_range(2) == 0) p[b] = ~p[b];
      r = ($urandom_range(79) == 0);
      step(r, p);
    end

    rep(1'b0, 2'b00, 6);
    @(negedge clk);
    @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
